// File: rtl/seq_priority_encoder_8to3_if.sv
// Vector-in / index-out handshake bundle for the 8-to-3 sequential encoder.
// slave is the encoder's view, master is the producer/consumer side.
interface seq_priority_encoder_8to3_if #(
   parameter int WIDTH = 8,
   parameter int IDX_W = 3
);
   logic [WIDTH-1:0] in_vec;
   logic             in_valid;
   logic             in_ready;
   logic [IDX_W-1:0] out_idx;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic             out_none;

   modport slave (
      input  in_vec, in_valid, out_ready,
      output in_ready, out_idx, out_valid, out_last, out_none
   );

   modport master (
      output in_vec, in_valid, out_ready,
      input  in_ready, out_idx, out_valid, out_last, out_none
   );
endinterface

// File: rtl/seq_priority_encoder_8to3.sv
// Serialises a multi-hot 8-bit vector into 3-bit indices, lowest bit first.
// Every output except in_ready comes straight from the state/pend registers.
module seq_priority_encoder_8to3 (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         enable,
   seq_priority_encoder_8to3_if.slave   bus,
   output logic                         busy
);
   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_pend;
   logic [7:0] w_pend_nxt;
   logic [7:0] w_low;
   logic [2:0] w_idx;
   logic       r_none;
   logic       w_none_nxt;
   logic       w_accept;
   logic       w_beat;
   logic       w_last;

   // Two's-complement trick isolates the lowest set bit as a one-hot word.
   assign w_low = r_pend & (~r_pend + 8'd1);

   always_comb begin
      w_idx = 3'd0;
      unique case (1'b1)
         w_low[0]: w_idx = 3'd0;
         w_low[1]: w_idx = 3'd1;
         w_low[2]: w_idx = 3'd2;
         w_low[3]: w_idx = 3'd3;
         w_low[4]: w_idx = 3'd4;
         w_low[5]: w_idx = 3'd5;
         w_low[6]: w_idx = 3'd6;
         w_low[7]: w_idx = 3'd7;
         default:  w_idx = 3'd0;
      endcase
   end

   assign w_last        = (r_state == EMIT) && (w_low == r_pend);
   assign bus.in_ready  = enable && (r_state == IDLE);
   assign bus.out_valid = (r_state == EMIT);
   assign bus.out_idx   = w_idx;
   assign bus.out_last  = w_last;
   assign bus.out_none  = r_none;
   assign busy          = (r_state == EMIT);

   assign w_accept = bus.in_valid && bus.in_ready;
   assign w_beat   = bus.out_valid && bus.out_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_pend_nxt  = r_pend;
      w_none_nxt  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (|bus.in_vec) begin
                  w_pend_nxt  = bus.in_vec;
                  w_state_nxt = EMIT;
               end else begin
                  w_none_nxt = 1'b1;
               end
            end
         end
         EMIT: begin
            if (w_beat) begin
               w_pend_nxt = r_pend & ~w_low;
               if (w_last) begin
                  w_state_nxt = IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_pend  <= 8'd0;
         r_none  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pend  <= w_pend_nxt;
         r_none  <= w_none_nxt;
      end
   end
endmodule

// File: tb/tb_seq_priority_encoder_8to3.sv
// Bench: queue-of-indices model checked every cycle, plus directed literals.
// Inputs change 1ns after posedge, everything is checked on negedge.
module tb_seq_priority_encoder_8to3;
   logic clk;
   logic rst_n;
   logic enable;
   logic busy;

   seq_priority_encoder_8to3_if bus_if ();

   seq_priority_encoder_8to3 dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .bus    (bus_if),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Model: a vector becomes a queue of its set-bit indices, drained one
   // per accepted beat; an empty queue means the block is idle.
   int unsigned q[$];
   logic        m_none;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_none = 1'b0;
      end else begin
         m_none = 1'b0;
         if (q.size() != 0) begin
            if (bus_if.out_ready) void'(q.pop_front());
         end else if (enable && bus_if.in_valid) begin
            if (bus_if.in_vec == 8'd0) m_none = 1'b1;
            for (int b = 0; b < 8; b++)
               if (bus_if.in_vec[b]) q.push_back(b);
         end
      end
   end

   always @(negedge clk) begin
      chk("in_ready", bus_if.in_ready, enable && q.size() == 0);
      chk("out_valid", bus_if.out_valid, q.size() != 0);
      chk("busy", busy, q.size() != 0);
      chk("out_none", bus_if.out_none, m_none);
      chk("out_idx", bus_if.out_idx, q.size() != 0 ? q[0] : 0);
      chk("out_last", bus_if.out_last, q.size() == 1);
      if (bus_if.out_none && bus_if.out_valid) chk("none_vs_valid", 1, 0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] v);
      bus_if.in_vec   = v;
      bus_if.in_valid = 1'b1;
      tick();
      bus_if.in_valid = 1'b0;
      bus_if.in_vec   = $urandom;
   endtask

   int unsigned exp3[3] = '{0, 2, 7};

   initial begin
      rst_n            = 1'b0;
      enable           = 1'b1;
      bus_if.in_vec    = 8'd0;
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b1;

      // reset with random inputs
      repeat (4) begin
         enable           = 1'($urandom);
         bus_if.in_valid  = 1'($urandom);
         bus_if.in_vec    = 8'($urandom);
         bus_if.out_ready = 1'($urandom);
         @(negedge clk);
         chk("rst_valid", bus_if.out_valid, 0);
         chk("rst_idx", bus_if.out_idx, 0);
         chk("rst_none", bus_if.out_none, 0);
         chk("rst_busy", busy, 0);
         tick();
      end
      enable           = 1'b1;
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b1;
      rst_n            = 1'b1;
      @(negedge clk);
      chk("rel_in_ready", bus_if.in_ready, 1);
      tick();

      // single bit
      send(8'b0010_0000);
      @(negedge clk);
      chk("s_idx", bus_if.out_idx, 5);
      chk("s_last", bus_if.out_last, 1);
      chk("s_in_ready", bus_if.in_ready, 0);
      tick();
      @(negedge clk);
      chk("s_idle", bus_if.in_ready, 1);
      tick();

      // multi-hot with backpressure
      bus_if.out_ready = 1'b0;
      send(8'b1000_0101);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_valid", bus_if.out_valid, 1);
         chk("bp_idx", bus_if.out_idx, 0);
         chk("bp_last", bus_if.out_last, 0);
         chk("bp_in_ready", bus_if.in_ready, 0);
         tick();
      end
      bus_if.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mh_idx", bus_if.out_idx, exp3[i]);
         chk("mh_last", bus_if.out_last, i == 2);
         tick();
      end

      // full vector, next accept on the 10th cycle
      send(8'hFF);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("ff_idx", bus_if.out_idx, i);
         chk("ff_last", bus_if.out_last, i == 7);
         tick();
      end
      @(negedge clk);
      chk("ff_idle_ready", bus_if.in_ready, 1);
      chk("ff_idle_valid", bus_if.out_valid, 0);
      send(8'h01);
      @(negedge clk);
      chk("ff_next_idx", bus_if.out_idx, 0);
      chk("ff_next_last", bus_if.out_last, 1);
      tick();

      // zero vector
      send(8'h00);
      @(negedge clk);
      chk("z_none", bus_if.out_none, 1);
      chk("z_valid", bus_if.out_valid, 0);
      tick();
      @(negedge clk);
      chk("z_none_clr", bus_if.out_none, 0);

      // enable low blocks capture
      enable          = 1'b0;
      bus_if.in_vec   = 8'h10;
      bus_if.in_valid = 1'b1;
      @(negedge clk);
      chk("en_ready", bus_if.in_ready, 0);
      tick();
      @(negedge clk);
      chk("en_nocap", bus_if.out_valid, 0);
      chk("en_busy", busy, 0);
      bus_if.in_valid = 1'b0;
      enable          = 1'b1;
      tick();

      // enable dropped mid-EMIT, stale in_valid held high
      send(8'b0000_0110);
      enable          = 1'b0;
      bus_if.in_vec   = 8'h80;
      bus_if.in_valid = 1'b1;
      @(negedge clk);
      chk("de_idx1", bus_if.out_idx, 1);
      tick();
      @(negedge clk);
      chk("de_idx2", bus_if.out_idx, 2);
      chk("de_last", bus_if.out_last, 1);
      tick();
      @(negedge clk);
      chk("de_done", bus_if.out_valid, 0);
      chk("de_ready", bus_if.in_ready, 0);
      tick();
      bus_if.in_valid = 1'b0;
      enable          = 1'b1;

      // async reset mid-EMIT
      send(8'b1111_0000);
      @(negedge clk);
      chk("ar_idx4", bus_if.out_idx, 4);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", bus_if.out_valid, 0);
      chk("ar_busy", busy, 0);
      chk("ar_idx", bus_if.out_idx, 0);
      tick();
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("ar_no_resid", bus_if.out_valid, 0);
      tick();
      send(8'b0000_1000);
      @(negedge clk);
      chk("ar_new_idx", bus_if.out_idx, 3);
      chk("ar_new_last", bus_if.out_last, 1);
      tick();
      @(negedge clk);
      chk("ar_end", bus_if.out_valid, 0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/seq_priority_encoder_8to3.md
Name: seq_priority_encoder_8to3

Overview:
Inverse companion to the team's 3-to-8 decoder. Accepts an 8-bit request vector over a valid/ready handshake, then serialises it into 3-bit binary indices, lowest set bit first, one index per output handshake. It sits between multi-hot status/interrupt vectors and logic that consumes one encoded index at a time.

Parameters:
WIDTH, 8, request vector width; fixed at 8 for this block.
IDX_W, 3, encoded index width; must equal log2(WIDTH).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  active-high; gates acceptance of new vectors only
in_vec  input  WIDTH  request vector (multi-hot allowed)
in_valid  input  1  in_vec valid
in_ready  output  1  block can accept a vector
out_idx  output  IDX_W  encoded index of the lowest pending bit
out_valid  output  1  out_idx valid
out_ready  input  1  consumer accepts out_idx
out_last  output  1  current out_idx is the last pending bit of the vector
out_none  output  1  one-cycle pulse: an all-zero vector was accepted
busy  output  1  high while in EMIT

Behaviour:
- Reset (async assert, sync release): state=IDLE, pend=0. out_valid=0, out_idx=0, out_last=0, out_none=0, busy=0. in_ready then follows enable.
- Internal state: 2-state FSM {IDLE, EMIT} and an 8-bit pend register.
- All outputs derive only from registers, except in_ready. No combinational path from in_vec, in_valid or out_ready to any output.
- in_ready = enable && state==IDLE.
- IDLE, accept (in_valid && in_ready):
  - in_vec!=0: pend<=in_vec, go to EMIT.
  - in_vec==0: stay in IDLE, out_none=1 for exactly the next cycle, no output beat.
- IDLE, no accept: pend holds, out_none=0.
- EMIT:
  - out_valid=1, busy=1.
  - out_idx = binary index of the lowest set bit of pend.
  - out_last = 1 when pend has exactly one bit set.
- EMIT handshake (out_valid && out_ready): clear that bit in pend. If out_last=1, go to IDLE (pend becomes 0).
- Backpressure: while out_ready=0, out_valid, out_idx and out_last hold stable. out_valid never drops before its handshake.
- enable deasserted in EMIT: emission continues to completion; only new acceptance is blocked.
- Latency and throughput:
  - Vector accepted at edge N gives first out_valid in cycle N+1.
  - With out_ready held at 1, one index per cycle.
  - After the last beat, one IDLE cycle before the next vector can be accepted. So k set bits take k+1 cycles per vector.
- in_vec is sampled only on acceptance; later changes are ignored.
- When in_ready=0, in_valid is ignored and nothing is captured.
- out_none and out_valid are never high together.
- Reset mid-EMIT: pend is discarded immediately, outputs return to reset values asynchronously, and no further beats are emitted.
- Index encoding: bit i of in_vec gives out_idx=i (unsigned, 0..7). Decoding out_idx with the 3-to-8 decoder (enable=1) yields 1<<i.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> out_valid=0, out_idx=0, out_none=0, busy=0. Release with enable=1 -> in_ready=1 next cycle.
- Single bit: in_vec=8'b0010_0000, out_ready=1 -> one beat, out_idx=5, out_last=1. Back in IDLE one cycle later, in_ready=1.
- Multi-hot with backpressure: in_vec=8'b1000_0101, out_ready low 3 cycles on the first beat -> out_idx=0 held stable 3 cycles, then beats 0, 2, 7. out_last=1 only on 7, in_ready=0 throughout.
- Full vector: in_vec=8'hFF, out_ready=1 -> out_idx 0..7 on 8 consecutive cycles, out_last only on 7. Next vector accepted on the 10th cycle after the first acceptance.
- Zero vector and enable: in_vec=8'h00 accepted -> out_none=1 for 1 cycle, out_valid stays 0. With enable=0 and in_valid=1 -> in_ready=0, nothing captured. Drop enable mid-EMIT on 8'b0000_0110 -> beats 1, 2 still emitted.
- Async reset mid-EMIT: in_vec=8'b1111_0000, assert rst_n=0 after first beat (idx 4) -> out_valid=0 without waiting for a clock edge. After release, no residual beats; new vector 8'b0000_1000 yields single beat idx 3.
